// File: rtl/cic_decim_nx_if.sv
`default_nettype none
// ============================================================================
// Module   : cic_decim_nx_if
// Brief    : Sample, control and result signals of the CIC decimator.
//            The master drives samples and controls, the slave (the filter)
//            returns decimated samples.
// Revision : 1.0 - initial release
// ============================================================================
interface cic_decim_nx_if #(
    parameter int INPUT_WIDTH  = 12,
    parameter int OUTPUT_WIDTH = 16,
    parameter int SHIFT_WIDTH  = 6
);
    logic                           flush;
    logic [15:0]                    factor;
    logic [SHIFT_WIDTH-1:0]         shift;
    logic                           in_valid;
    logic signed [INPUT_WIDTH-1:0]  in_data;
    logic                           out_valid;
    logic signed [OUTPUT_WIDTH-1:0] out_data;
    logic                           out_sat;

    modport master (
        output flush, factor, shift, in_valid, in_data,
        input  out_valid, out_data, out_sat
    );

    modport slave (
        input  flush, factor, shift, in_valid, in_data,
        output out_valid, out_data, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/cic_decim_nx.sv
`default_nettype none
// ============================================================================
// Module   : cic_decim_nx
// Brief    : N-stage CIC decimator with runtime factor, pipelined combs and
//            round-half-up / saturating output scaling.
// Revision : 1.0 - initial release
// ============================================================================
module cic_decim_nx #(
    parameter int INPUT_WIDTH     = 12,
    parameter int OUTPUT_WIDTH    = 16,
    parameter int STAGES          = 4,
    parameter int FACTOR_LOG2_MAX = 6,
    parameter int SHIFT_WIDTH     = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    cic_decim_nx_if.slave   bus
);
    localparam int c_w  = INPUT_WIDTH + STAGES * FACTOR_LOG2_MAX;
    localparam int c_fw = FACTOR_LOG2_MAX + 1;
    localparam logic [c_fw-1:0]       c_fmax    = {1'b1, {FACTOR_LOG2_MAX{1'b0}}};
    localparam logic signed [c_w:0]   c_one     = {{c_w{1'b0}}, 1'b1};
    localparam logic signed [c_w:0]   c_out_max =
        {{(c_w - OUTPUT_WIDTH + 2){1'b0}}, {(OUTPUT_WIDTH - 1){1'b1}}};
    localparam logic signed [c_w:0]   c_out_min = ~c_out_max;

    logic [FACTOR_LOG2_MAX-1:0] r_phase;
    logic [c_fw-1:0]            r_fa;
    logic signed [c_w-1:0]      r_integ [STAGES];
    logic signed [c_w-1:0]      r_dly   [STAGES];
    logic signed [c_w-1:0]      r_pipe  [STAGES];
    logic [SHIFT_WIDTH-1:0]     r_sh    [STAGES];
    logic [STAGES-1:0]          r_tok;

    logic [c_fw-1:0]            w_factor_clamped;
    logic [c_fw-1:0]            w_fa_eff;
    logic                       w_accept;
    logic                       w_last;
    logic                       w_event;
    logic signed [c_w:0]        w_c_ext;
    logic signed [c_w:0]        w_scaled;
    logic [SHIFT_WIDTH-1:0]     w_sh;
    logic                       w_over;
    logic                       w_under;

    // Clamp the requested factor into 1..2^FACTOR_LOG2_MAX and pick the active period.
    always_comb begin
        w_factor_clamped = bus.factor[c_fw-1:0];
        if (bus.factor == 16'd0) begin
            w_factor_clamped = c_fw'(1);
        end else if (bus.factor > {{(16 - c_fw){1'b0}}, c_fmax}) begin
            w_factor_clamped = c_fmax;
        end
        // A zero active factor only exists straight after reset; use the request directly.
        w_fa_eff = (r_fa == '0) ? w_factor_clamped : r_fa;
        w_accept = bus.in_valid & ~bus.flush;
        w_last   = ({1'b0, r_phase} == (w_fa_eff - c_fw'(1)));
        w_event  = w_accept & w_last;
    end

    // Phase counter; the active factor reloads at each period boundary and on flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
            r_fa    <= '0;
        end else if (bus.flush) begin
            r_phase <= '0;
            r_fa    <= w_factor_clamped;
        end else begin
            r_fa <= w_fa_eff;
            if (w_accept) begin
                if (w_last) begin
                    r_phase <= '0;
                    r_fa    <= w_factor_clamped;
                end else begin
                    r_phase <= r_phase + FACTOR_LOG2_MAX'(1);
                end
            end
        end
    end

    // Integrator chain, advancing once per accepted sample, wrapping modulo 2^W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) r_integ[k] <= '0;
        end else if (bus.flush) begin
            for (int k = 0; k < STAGES; k++) r_integ[k] <= '0;
        end else if (w_accept) begin
            r_integ[0] <= r_integ[0]
                + {{(c_w - INPUT_WIDTH){bus.in_data[INPUT_WIDTH-1]}}, bus.in_data};
            for (int k = 1; k < STAGES; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
        end
    end

    // Comb pipeline: one stage per cycle behind a free-running valid token.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tok <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_dly[k]  <= '0;
                r_pipe[k] <= '0;
                r_sh[k]   <= '0;
            end
        end else if (bus.flush) begin
            r_tok <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_dly[k]  <= '0;
                r_pipe[k] <= '0;
                r_sh[k]   <= '0;
            end
        end else begin
            r_tok[0] <= w_event;
            if (w_event) begin
                r_pipe[0] <= r_integ[STAGES-1] - r_dly[0];
                r_dly[0]  <= r_integ[STAGES-1];
                r_sh[0]   <= bus.shift;
            end
            for (int k = 1; k < STAGES; k++) begin
                r_tok[k] <= r_tok[k-1];
                if (r_tok[k-1]) begin
                    r_pipe[k] <= r_pipe[k-1] - r_dly[k];
                    r_dly[k]  <= r_pipe[k-1];
                    r_sh[k]   <= r_sh[k-1];
                end
            end
        end
    end

    // Round-half-up arithmetic shift of the comb result, then saturation detect.
    always_comb begin
        w_sh     = r_sh[STAGES-1];
        w_c_ext  = {r_pipe[STAGES-1][c_w-1], r_pipe[STAGES-1]};
        w_scaled = w_c_ext;
        if (32'(w_sh) >= c_w) begin
            // The rounding offset dominates any comb value, so the result is zero.
            w_scaled = '0;
        end else if (w_sh != '0) begin
            w_scaled = (w_c_ext + (c_one << (w_sh - SHIFT_WIDTH'(1)))) >>> w_sh;
        end
        w_over  = (w_scaled > c_out_max);
        w_under = (w_scaled < c_out_min);
    end

    // Output register: written only when the token leaves the last comb stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= r_tok[STAGES-1];
            if (r_tok[STAGES-1]) begin
                bus.out_sat <= w_over | w_under;
                if (w_over) begin
                    bus.out_data <= c_out_max[OUTPUT_WIDTH-1:0];
                end else if (w_under) begin
                    bus.out_data <= c_out_min[OUTPUT_WIDTH-1:0];
                end else begin
                    bus.out_data <= w_scaled[OUTPUT_WIDTH-1:0];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cic_decim_nx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_decim_nx
// Brief    : Self-checking bench for cic_decim_nx against a sample-domain
//            reference model with a fixed-latency scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cic_decim_nx;
    localparam int IW = 12;
    localparam int OW = 16;
    localparam int ST = 4;
    localparam int FL = 6;
    localparam int SW = 6;
    localparam int W  = IW + ST * FL;

    typedef logic signed [W-1:0] acc_t;
    typedef struct {
        int     due;
        longint d;
        bit     s;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    cic_decim_nx_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .SHIFT_WIDTH(SW)) bus_if ();

    cic_decim_nx #(
        .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .STAGES(ST),
        .FACTOR_LOG2_MAX(FL), .SHIFT_WIDTH(SW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_if)
    );

    int     n_total = 0;
    int     n_bad   = 0;
    int     cyc     = 0;
    acc_t   m_int [ST];
    acc_t   m_dly [ST];
    int     m_phase;
    int     m_fa;
    exp_t   pend[$];
    longint rec[$];
    longint mrec[$];

    task automatic check(string tag, longint obs, longint exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int clampf(int f);
        if (f == 0) return 1;
        if (f > (1 << FL)) return 1 << FL;
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ST; k++) begin
            m_int[k] = '0;
            m_dly[k] = '0;
        end
        m_phase = 0;
        m_fa    = 0;
        pend.delete();
    endtask

    // Decimated sample: comb difference chain, rounding shift, saturation.
    task automatic emit(acc_t v, int sh);
        acc_t   c;
        acc_t   t;
        longint y;
        bit     s;
        c = v;
        for (int k = 0; k < ST; k++) begin
            t        = c - m_dly[k];
            m_dly[k] = c;
            c        = t;
        end
        y = longint'(c);
        if (sh > 0) y = (y + (longint'(1) <<< (sh - 1))) >>> sh;
        s = 1'b0;
        if (y > 32767) begin
            y = 32767;
            s = 1'b1;
        end else if (y < -32768) begin
            y = -32768;
            s = 1'b1;
        end
        pend.push_back('{cyc + ST, y, s});
        mrec.push_back(y);
    endtask

    task automatic model_edge();
        int                   fa;
        acc_t                 v;
        logic signed [IW-1:0] din;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (bus_if.flush) begin
            model_reset();
            m_fa = clampf(int'(bus_if.factor));
            return;
        end
        fa   = (m_fa == 0) ? clampf(int'(bus_if.factor)) : m_fa;
        m_fa = fa;
        if (bus_if.in_valid) begin
            v   = m_int[ST-1];
            din = bus_if.in_data;
            for (int k = ST - 1; k > 0; k--) m_int[k] = m_int[k] + m_int[k-1];
            m_int[0] = m_int[0] + {{(W - IW){din[IW-1]}}, din};
            if (m_phase == fa - 1) begin
                m_phase = 0;
                m_fa    = clampf(int'(bus_if.factor));
                emit(v, int'(bus_if.shift));
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic compare_outputs();
        bit ev;
        ev = (pend.size() > 0) && (pend[0].due == cyc);
        check("out_valid", longint'(bus_if.out_valid), longint'(ev));
        if (ev) begin
            check("out_data", longint'(bus_if.out_data), pend[0].d);
            check("out_sat", longint'(bus_if.out_sat), longint'(pend[0].s));
            void'(pend.pop_front());
        end
        if (bus_if.out_valid) rec.push_back(longint'(bus_if.out_data));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic cycle_in(bit f, bit v, int d);
        bus_if.flush    = f;
        bus_if.in_valid = v;
        bus_if.in_data  = IW'(d);
        tick();
        bus_if.flush    = 1'b0;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic drive(int d);
        cycle_in(1'b0, 1'b1, d);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle_in(1'b0, 1'b0, 0);
    endtask

    task automatic restart(int f, int sh);
        bus_if.factor = 16'(f);
        bus_if.shift  = SW'(sh);
        cycle_in(1'b1, 1'b0, 0);
        rec.delete();
        mrec.delete();
    endtask

    initial begin
        longint sum;
        longint mref[$];
        int     gdata[40];

        bus_if.flush    = 1'b0;
        bus_if.factor   = 16'd4;
        bus_if.shift    = SW'(8);
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        model_reset();
        repeat (3) tick();
        check("rst_valid", longint'(bus_if.out_valid), 0);
        check("rst_data", longint'(bus_if.out_data), 0);
        check("rst_sat", longint'(bus_if.out_sat), 0);
        reset_n = 1'b1;

        // DC: gain 4^4 = 256 removed by shift 8
        rec.delete();
        repeat (40) drive(100);
        idle(ST + 2);
        check("dc_count", longint'(rec.size()), 10);
        if (rec.size() > 0) check("dc_last", rec[rec.size()-1], 100);
        check("dc_sat", longint'(bus_if.out_sat), 0);

        // Impulse: decimated response sums to R^(N-1)
        restart(4, 0);
        drive(1);
        repeat (39) drive(0);
        idle(ST + 2);
        sum = 0;
        foreach (rec[i]) sum += rec[i];
        check("imp_sum", sum, 64);
        check("imp_count", longint'(rec.size()), 10);

        // Rounding: 16/32 rounds up to 1
        restart(2, 5);
        repeat (30) drive(1);
        idle(ST + 2);
        if (rec.size() > 0) check("round_last", rec[rec.size()-1], 1);

        // Saturation both directions
        restart(16, 0);
        repeat (128) drive(2047);
        idle(ST + 2);
        if (rec.size() > 0) check("satp_last", rec[rec.size()-1], 32767);
        check("satp_flag", longint'(bus_if.out_sat), 1);
        restart(16, 0);
        repeat (128) drive(-2048);
        idle(ST + 2);
        if (rec.size() > 0) check("satn_last", rec[rec.size()-1], -32768);
        check("satn_flag", longint'(bus_if.out_sat), 1);

        // Factor change 4 -> 8 at phase 2: periods 4, 8, 8, 8 over 32 samples
        restart(4, 0);
        repeat (2) drive(int'($urandom_range(0, 4095)));
        bus_if.factor = 16'd8;
        repeat (30) drive(int'($urandom_range(0, 4095)));
        idle(ST + 2);
        check("fchg_count", longint'(rec.size()), 4);

        // factor 0 acts as 1: one output per accepted sample
        restart(0, 3);
        repeat (10) drive(int'($urandom_range(0, 4095)));
        idle(ST + 2);
        check("f0_count", longint'(rec.size()), 10);

        // in_valid gaps must not change the output sequence
        foreach (gdata[i]) gdata[i] = int'($urandom_range(0, 4095));
        restart(4, 4);
        foreach (gdata[i]) drive(gdata[i]);
        idle(ST + 2);
        mref = mrec;
        restart(4, 4);
        foreach (gdata[i]) begin
            if ($urandom_range(0, 1) == 0) idle(1);
            drive(gdata[i]);
        end
        idle(ST + 2);
        check("gap_count", longint'(rec.size()), longint'(mref.size()));
        foreach (mref[i]) if (i < rec.size()) check("gap_data", rec[i], mref[i]);

        // Flush with three tokens in flight discards them
        restart(1, 0);
        repeat (3) drive(int'($urandom_range(1, 2000)));
        cycle_in(1'b1, 1'b0, 0);
        idle(ST + 3);
        check("flush_drop", longint'(rec.size()), 0);
        repeat (8) drive(int'($urandom_range(0, 4095)));
        idle(ST + 2);

        // Asynchronous reset mid-burst, then cold start
        restart(1, 2);
        repeat (10) drive(int'($urandom_range(256, 2047)));
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_valid", longint'(bus_if.out_valid), 0);
        check("arst_data", longint'(bus_if.out_data), 0);
        check("arst_sat", longint'(bus_if.out_sat), 0);
        model_reset();
        repeat (2) drive(int'($urandom_range(0, 4095)));
        reset_n = 1'b1;
        repeat (12) drive(int'($urandom_range(0, 4095)));
        idle(ST + 2);

        // Random mix of factors, shifts, gaps and flushes
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) begin
                bus_if.factor = 16'($urandom_range(0, 70));
                bus_if.shift  = SW'($urandom_range(0, 14));
            end
            cycle_in($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                     int'($urandom_range(0, 4095)));
        end
        idle(ST + 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
